// File: rtl/vend_pkg.sv
// Shared vending definitions: dispenser state encoding and coin denominations.
package vend_pkg;

  typedef enum logic [2:0] {
    DS_IDLE  = 3'd0,
    DS_SEL   = 3'd1,
    DS_EJ10  = 3'd2,
    DS_EJ5   = 3'd3,
    DS_DONE  = 3'd4,
    DS_FAULT = 3'd5
  } disp_state_e;

  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;

  // Only whole multiples of the smallest coin can be paid out.
  function automatic logic is_payable(input int amt);
    return (amt % COIN_5) == 0;
  endfunction

endpackage

// File: rtl/vend_ack_timer.sv
// Counts cycles an eject request has waited for its ack.
// expired_o flags the last allowed unacked cycle so the caller faults at that edge.
module vend_ack_timer #(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/vend_change_dispenser.sv
// Pays a change amount out as 10- then 5-unit coins over a req/ack ejector handshake.
// All outputs decode from state or registers; faults on illegal amount or ejector timeout.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amt,
  output logic             change_ready,
  output logic             eject_10,
  output logic             eject_5,
  input  logic             eject_ack,
  output logic             done,
  output logic [AMT_W-1:0] n10_out,
  output logic [AMT_W-1:0] n5_out,
  output logic             fault,
  input  logic             fault_clr
);

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] n10_q, n10_d;
  logic [AMT_W-1:0] n5_q, n5_d;
  logic             in_eject;
  logic             ack_expired;

  assign in_eject = (state_q == DS_EJ10) || (state_q == DS_EJ5);

  vend_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .CNT_W      (8)
  ) u_ack_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!in_eject || eject_ack),
    .en_i     (in_eject && !eject_ack),
    .expired_o(ack_expired)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    n10_d   = n10_q;
    n5_d    = n5_q;
    case (state_q)
      DS_IDLE: begin
        if (change_valid) begin
          rem_d   = change_amt;
          n10_d   = '0;
          n5_d    = '0;
          state_d = is_payable(int'(change_amt)) ? DS_SEL : DS_FAULT;
        end
      end
      DS_SEL: begin
        if (int'(rem_q) >= COIN_10) begin
          state_d = DS_EJ10;
        end else if (int'(rem_q) >= COIN_5) begin
          state_d = DS_EJ5;
        end else begin
          state_d = DS_DONE;
        end
      end
      DS_EJ10: begin
        if (eject_ack) begin
          rem_d   = rem_q - AMT_W'(COIN_10);
          n10_d   = (n10_q == '1) ? n10_q : n10_q + 1'b1;
          state_d = DS_SEL;
        end else if (ack_expired) begin
          state_d = DS_FAULT;
        end
      end
      DS_EJ5: begin
        if (eject_ack) begin
          rem_d   = rem_q - AMT_W'(COIN_5);
          n5_d    = (n5_q == '1) ? n5_q : n5_q + 1'b1;
          state_d = DS_SEL;
        end else if (ack_expired) begin
          state_d = DS_FAULT;
        end
      end
      DS_DONE: begin
        state_d = DS_IDLE;
      end
      DS_FAULT: begin
        if (fault_clr) begin
          state_d = DS_IDLE;
        end
      end
      default: begin
        state_d = DS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DS_IDLE;
      rem_q   <= '0;
      n10_q   <= '0;
      n5_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      n10_q   <= n10_d;
      n5_q    <= n5_d;
    end
  end

  assign change_ready = (state_q == DS_IDLE);
  assign eject_10     = (state_q == DS_EJ10);
  assign eject_5      = (state_q == DS_EJ5);
  assign done         = (state_q == DS_DONE);
  assign fault        = (state_q == DS_FAULT);
  assign n10_out      = n10_q;
  assign n5_out       = n5_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Bench for vend_change_dispenser: directed scenarios plus random amounts and ack delays
// checked against a greedy-payout timing model.
module tb_vend_change_dispenser;

  localparam int AMT_W  = 4;
  localparam int T_OUT  = 15;
  localparam int BUDGET = 200;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             change_valid = 1'b0;
  logic [AMT_W-1:0] change_amt = '0;
  logic             change_ready;
  logic             eject_10;
  logic             eject_5;
  logic             eject_ack = 1'b0;
  logic             done;
  logic [AMT_W-1:0] n10_out;
  logic [AMT_W-1:0] n5_out;
  logic             fault;
  logic             fault_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vend_change_dispenser #(
    .AMT_W      (AMT_W),
    .ACK_TIMEOUT(T_OUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .change_valid(change_valid),
    .change_amt  (change_amt),
    .change_ready(change_ready),
    .eject_10    (eject_10),
    .eject_5     (eject_5),
    .eject_ack   (eject_ack),
    .done        (done),
    .n10_out     (n10_out),
    .n5_out      (n5_out),
    .fault       (fault),
    .fault_clr   (fault_clr)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ready"}, int'(change_ready), 1);
    check_eq({tag, "_ej10"}, int'(eject_10), 0);
    check_eq({tag, "_ej5"}, int'(eject_5), 0);
    check_eq({tag, "_done"}, int'(done), 0);
    check_eq({tag, "_fault"}, int'(fault), 0);
    check_eq({tag, "_n10"}, int'(n10_out), 0);
    check_eq({tag, "_n5"}, int'(n5_out), 0);
  endtask

  // Offers one amount, answers each eject request after dly extra cycles
  // (dly >= T_OUT means never) and compares what happened to the greedy model.
  task automatic run_txn(input int amt, input int dly, input bit noise);
    int  c, run_len, done_c, fault_c;
    int  coin_start[$];
    int  coin_len[$];
    int  coin_ten[$];
    int  exp_n10, exp_n5, ncoins, ncmp;
    bit  illegal, stuck;

    exp_n10 = amt / 10;
    exp_n5  = (amt % 10) / 5;
    illegal = (amt % 5) != 0;
    ncoins  = illegal ? 0 : exp_n10 + exp_n5;
    stuck   = !illegal && ncoins > 0 && dly >= T_OUT;

    @(negedge clk);
    check_eq("ready_before_accept", int'(change_ready), 1);
    change_valid = 1'b1;
    change_amt   = AMT_W'(amt);
    @(negedge clk);
    change_valid = 1'b0;
    c = 1; run_len = 0; done_c = -1; fault_c = -1;
    while (c <= BUDGET) begin
      if (eject_10 && eject_5) check_eq("eject_exclusive", 1, 0);
      if (eject_10 || eject_5) begin
        if (run_len == 0) begin
          coin_start.push_back(c);
          coin_ten.push_back(int'(eject_10));
          coin_len.push_back(0);
        end
        run_len++;
        coin_len[coin_len.size()-1] = run_len;
        eject_ack = (dly < T_OUT) && (run_len == dly + 1);
      end else begin
        run_len   = 0;
        eject_ack = noise ? 1'($urandom_range(1)) : 1'b0;
      end
      if (done)  done_c  = c;
      if (fault) fault_c = c;
      if (done_c >= 0 || fault_c >= 0) break;
      @(negedge clk);
      c++;
    end
    eject_ack = 1'b0;
    check_eq("txn_ended_in_budget", int'(done_c >= 0 || fault_c >= 0), 1);

    if (illegal) begin
      check_eq("illegal_fault_cycle", fault_c, 1);
      check_eq("illegal_no_coins", coin_start.size(), 0);
      check_eq("illegal_ready_low", int'(change_ready), 0);
      check_eq("illegal_n10", int'(n10_out), 0);
      check_eq("illegal_n5", int'(n5_out), 0);
    end else if (stuck) begin
      check_eq("timeout_fault_cycle", fault_c, 2 + T_OUT);
      check_eq("timeout_one_coin", coin_start.size(), 1);
      if (coin_start.size() > 0) begin
        check_eq("timeout_req_len", coin_len[0], T_OUT);
        check_eq("timeout_req_is10", coin_ten[0], int'(exp_n10 > 0));
      end
      check_eq("timeout_ej10_low", int'(eject_10), 0);
      check_eq("timeout_ej5_low", int'(eject_5), 0);
      check_eq("timeout_n10", int'(n10_out), 0);
      check_eq("timeout_n5", int'(n5_out), 0);
    end else begin
      check_eq("done_cycle", done_c, 2 + ncoins * (dly + 2));
      check_eq("coin_count", coin_start.size(), ncoins);
      ncmp = (coin_start.size() < ncoins) ? coin_start.size() : ncoins;
      for (int i = 0; i < ncmp; i++) begin
        check_eq("coin_start", coin_start[i], 2 + i * (dly + 2));
        check_eq("coin_len", coin_len[i], dly + 1);
        check_eq("coin_is10", coin_ten[i], int'(i < exp_n10));
      end
      check_eq("n10_at_done", int'(n10_out), exp_n10);
      check_eq("n5_at_done", int'(n5_out), exp_n5);
      @(negedge clk);
      check_eq("done_one_cycle", int'(done), 0);
      check_eq("ready_after_done", int'(change_ready), 1);
      check_eq("n10_held", int'(n10_out), exp_n10);
      check_eq("n5_held", int'(n5_out), exp_n5);
    end
  endtask

  // Called while in FAULT: offered amounts must be ignored, then fault_clr recovers.
  task automatic recover_fault();
    for (int i = 0; i < 3; i++) begin
      change_valid = 1'b1;
      change_amt   = AMT_W'(5);
      @(negedge clk);
      check_eq("fault_sticky", int'(fault), 1);
      check_eq("fault_no_ready", int'(change_ready), 0);
      check_eq("fault_no_eject", int'(eject_10 | eject_5), 0);
    end
    change_valid = 1'b0;
    fault_clr    = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check_eq("fault_cleared", int'(fault), 0);
    check_eq("ready_after_clr", int'(change_ready), 1);
  endtask

  initial begin
    #12;
    check_idle_outputs("in_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");

    run_txn(15, 0, 1'b0);
    run_txn(10, 3, 1'b0);
    run_txn(0, 0, 1'b0);
    run_txn(7, 0, 1'b0);
    recover_fault();
    run_txn(5, 0, 1'b0);
    run_txn(5, 99, 1'b0);
    recover_fault();

    // Asynchronous reset while a 10-coin request is outstanding.
    @(negedge clk);
    change_valid = 1'b1;
    change_amt   = AMT_W'(15);
    @(negedge clk);
    change_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_reset_ej10", int'(eject_10), 1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    run_txn(10, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int amt, dly;
      amt = int'($urandom_range(15));
      dly = ($urandom_range(7) == 0) ? T_OUT + int'($urandom_range(2)) : int'($urandom_range(4));
      run_txn(amt, dly, 1'b1);
      if (fault) recover_fault();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
Downstream stage of the vending FSM. Accepts the computed change amount and pays it out as physical 10- and 5-unit coins, one at a time, through a request/acknowledge handshake with the coin-ejector mechanism. It uses a greedy algorithm: 10s first, then 5s. It reports completion, per-transaction coin counts, and faults (illegal amount or ejector timeout).

Parameters:
AMT_W, 4, width of change amount and internal remaining/count registers
ACK_TIMEOUT, 15, cycles an eject request may wait for eject_ack before FAULT (1..2^8-1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
change_valid  input  1  change_amt valid from vending FSM
change_amt  input  AMT_W  change to pay out, in currency units
change_ready  output  1  dispenser idle, can accept an amount
eject_10  output  1  request ejector to release one 10-unit coin (held until ack)
eject_5  output  1  request ejector to release one 5-unit coin (held until ack)
eject_ack  input  1  ejector has released the requested coin
done  output  1  one-cycle pulse: transaction fully paid
n10_out  output  AMT_W  10-coins paid in last transaction (valid from done, held until next accept)
n5_out  output  AMT_W  5-coins paid in last transaction (same validity)
fault  output  1  sticky fault flag
fault_clr  input  1  clears FAULT, returns to IDLE

Behaviour:
- Reset (async, any state): state=IDLE; remaining, n10_out, n5_out, timeout counter=0; eject_10=eject_5=done=fault=0; change_ready=1 once in IDLE. A mid-ejection reset drops the request immediately, and the partial payout is lost.
- States: IDLE, SEL, EJ10, EJ5, DONE, FAULT. All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- IDLE: change_ready=1. On change_valid && change_ready at the edge:
  - Capture remaining=change_amt and clear n10_out and n5_out.
  - If change_amt mod 5 != 0, go to FAULT (nothing captured is paid).
  - Otherwise go to SEL.
  - change_valid in any other state is ignored. Upstream must hold it until ready.
- SEL: if remaining>=10 go to EJ10; else if remaining>=5 go to EJ5; else (remaining==0) go to DONE.
- EJ10 / EJ5: assert eject_10 or eject_5 respectively.
  - eject_ack sampled high at the edge: remaining -= 10 or 5, increment n10_out or n5_out, clear the timeout counter, go to SEL.
  - An ack present on the first cycle of the request counts.
  - Otherwise the timeout counter increments. When it reaches ACK_TIMEOUT, go to FAULT with remaining unchanged.
- eject_ack outside EJ10/EJ5 is ignored.
- DONE: done=1 for exactly one cycle, then IDLE. A zero amount goes IDLE→SEL→DONE with no eject.
- FAULT: fault=1, change_ready=0, no ejects. fault_clr sampled high goes to IDLE and clears fault. fault_clr in other states is ignored.
- Arithmetic: subtraction never underflows, guaranteed by the SEL compare. Counts saturate at 2^AMT_W-1 (unreachable at default width).
- Latency, amount 15 with immediate acks: accept edge 0; SEL 1; EJ10 2; SEL 3; EJ5 4; SEL 5; DONE 6; IDLE/ready at 7.

Decomposition:
- Shared package vend_pkg holds:
  - State encoding constants: DS_IDLE, DS_SEL, DS_EJ10, DS_EJ5, DS_DONE, DS_FAULT.
  - Coin denominations COIN_5=5 and COIN_10=10, shared with the vending FSM's price/change logic.
- One sub-module is natural: vend_ack_timer, the timeout counter with clear/enable/expired, parameterised by ACK_TIMEOUT.

Test Plan:
- Amount 15, ack asserted every request cycle → eject_10 at cycle 2, eject_5 at cycle 4, done at cycle 6, n10_out=1, n5_out=1, ready again at cycle 7.
- Amount 10, ack delayed 3 cycles → eject_10 held exactly 4 cycles, no eject_5, done pulse, n10_out=1, n5_out=0.
- Amount 0 → no eject ever asserted, done pulses at cycle 2, both counts 0.
- Amount 7 → fault=1 next cycle, change_ready=0, no ejects. fault_clr → IDLE, fault=0, a subsequent amount 5 pays one 5-coin.
- Amount 5, ack never given → eject_5 held ACK_TIMEOUT(15) cycles then fault=1, eject_5=0. change_valid during FAULT is ignored.
- Amount 15, rst pulsed while eject_10 high → eject_10 drops asynchronously, all outputs at reset values. A fresh amount 10 completes normally with n10_out=1.
